// File: rtl/pong_pkg.sv
// Shared Pong constants and types for the ball controller.
// Contents:
//   - screen, ball and paddle geometry as localparams
//   - ball_state_t : SERVE / MOVING / OUT
//   - dir_t        : 1-bit direction, POS = increasing coordinate
//   - to_s11()     : zero-extend a 10-bit coordinate into signed 11-bit math
package pong_pkg;

  localparam int unsigned SCREEN_W       = 640;
  localparam int unsigned SCREEN_H       = 480;
  localparam int unsigned BALL_R         = 5;
  localparam int unsigned PADDLE_W       = 8;
  localparam int unsigned PADDLE_H       = 48;
  localparam int unsigned LEFT_PADDLE_X  = 20;
  localparam int unsigned RIGHT_PADDLE_X = 612;
  localparam int unsigned SPEED_X        = 2;
  localparam int unsigned SPEED_Y        = 1;
  localparam int unsigned SERVE_FRAMES   = 60;

  localparam int unsigned POS_W = 10;
  localparam int unsigned CNT_W = 6;

  // Derived geometry (ball centre limits, rebound positions, centre spot)
  localparam int unsigned X_MIN    = BALL_R;
  localparam int unsigned X_MAX    = SCREEN_W - 1 - BALL_R;
  localparam int unsigned Y_MIN    = BALL_R;
  localparam int unsigned Y_MAX    = SCREEN_H - 1 - BALL_R;
  localparam int unsigned CENTER_X = SCREEN_W / 2;
  localparam int unsigned CENTER_Y = SCREEN_H / 2;
  localparam int unsigned LEFT_FACE       = LEFT_PADDLE_X + PADDLE_W - 1;
  localparam int unsigned LEFT_REBOUND_X  = LEFT_PADDLE_X + PADDLE_W + BALL_R;
  localparam int unsigned RIGHT_REBOUND_X = RIGHT_PADDLE_X - BALL_R;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    MOVING = 2'd1,
    OUT    = 2'd2
  } ball_state_t;

  typedef enum logic {
    NEG = 1'b0,
    POS = 1'b1
  } dir_t;

  function automatic logic signed [POS_W:0] to_s11(input logic [POS_W-1:0] v);
    return signed'({1'b0, v});
  endfunction

endpackage

// File: rtl/paddle_hit_check.sv
// Combinational paddle overlap test for one side of the court.
// Ports:
//   ball_y     in  10  ball centre y before this frame's vertical update
//   paddle_top in  10  paddle top row
//   crossing   in   1  ball is moving toward this paddle and crosses its face this frame
//   hit        out  1  crossing and the ball's vertical extent overlaps the paddle
module paddle_hit_check
  import pong_pkg::*;
(
  input  logic [POS_W-1:0] ball_y,
  input  logic [POS_W-1:0] paddle_top,
  input  logic             crossing,
  output logic             hit
);

  logic [POS_W:0] ball_bottom;
  logic [POS_W:0] top_ext;
  logic [POS_W:0] reach_limit;

  assign ball_bottom = {1'b0, ball_y} + (POS_W+1)'(BALL_R);
  assign top_ext     = {1'b0, paddle_top};
  // y-R <= top+H-1 rewritten as y <= top+H-1+R so nothing can go negative
  assign reach_limit = top_ext + (POS_W+1)'(PADDLE_H - 1 + BALL_R);

  assign hit = crossing
             && (ball_bottom >= top_ext)
             && ({1'b0, ball_y} <= reach_limit);

endmodule

// File: rtl/ball_controller.sv
// Pong ball controller: position, direction, wall bounces, paddle rebounds
// and serve timing. All motion is evaluated once per frame on frame_tick.
// Ports:
//   clk            in   1  system clock
//   reset_n        in   1  async active-low reset (score keeper goal reset ANDed with global reset)
//   frame_tick     in   1  one-cycle pulse per video frame
//   serve_right    in   1  launch direction at the end of the serve hold (1 = +x)
//   left_paddle_y  in  10  left paddle top row
//   right_paddle_y in  10  right paddle top row
//   ball_x_pos     out 10  ball centre x
//   ball_y_pos     out 10  ball centre y
//   paddle_hit     out  1  one-cycle pulse on a paddle rebound
//   in_play        out  1  high while the ball is moving
module ball_controller
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_tick,
  input  logic             serve_right,
  input  logic [POS_W-1:0] left_paddle_y,
  input  logic [POS_W-1:0] right_paddle_y,
  output logic [POS_W-1:0] ball_x_pos,
  output logic [POS_W-1:0] ball_y_pos,
  output logic             paddle_hit,
  output logic             in_play
);

  localparam logic signed [POS_W:0] SPD_X_S = (POS_W+1)'(SPEED_X);
  localparam logic signed [POS_W:0] SPD_Y_S = (POS_W+1)'(SPEED_Y);
  localparam logic signed [POS_W:0] X_MIN_S = (POS_W+1)'(X_MIN);
  localparam logic signed [POS_W:0] X_MAX_S = (POS_W+1)'(X_MAX);
  localparam logic signed [POS_W:0] Y_MIN_S = (POS_W+1)'(Y_MIN);
  localparam logic signed [POS_W:0] Y_MAX_S = (POS_W+1)'(Y_MAX);
  // Face tests with BALL_R folded in: x-R vs LEFT_FACE, x+R vs RIGHT_PADDLE_X
  localparam logic signed [POS_W:0] L_CROSS_S = (POS_W+1)'(LEFT_FACE + BALL_R);
  localparam logic signed [POS_W:0] R_CROSS_S = (POS_W+1)'(RIGHT_PADDLE_X - BALL_R);

  ball_state_t      state_q, state_nx;
  dir_t             dx_q, dx_nx;
  dir_t             dy_q, dy_nx;
  logic [POS_W-1:0] x_q, x_nx;
  logic [POS_W-1:0] y_q, y_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             hit_q, hit_nx;

  logic signed [POS_W:0] x_s, y_s, nx, ny;
  logic                  cross_l, cross_r;
  logic                  hit_l, hit_r;

  assign x_s = to_s11(x_q);
  assign y_s = to_s11(y_q);
  assign nx  = (dx_q == POS) ? (x_s + SPD_X_S) : (x_s - SPD_X_S);
  assign ny  = (dy_q == POS) ? (y_s + SPD_Y_S) : (y_s - SPD_Y_S);

  assign cross_l = (dx_q == NEG) && (nx <= L_CROSS_S) && (x_s > L_CROSS_S);
  assign cross_r = (dx_q == POS) && (nx >= R_CROSS_S) && (x_s < R_CROSS_S);

  paddle_hit_check u_left_check (
    .ball_y     (y_q),
    .paddle_top (left_paddle_y),
    .crossing   (cross_l),
    .hit        (hit_l)
  );

  paddle_hit_check u_right_check (
    .ball_y     (y_q),
    .paddle_top (right_paddle_y),
    .crossing   (cross_r),
    .hit        (hit_r)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SERVE;
      dx_q    <= POS;
      dy_q    <= POS;
      x_q     <= POS_W'(CENTER_X);
      y_q     <= POS_W'(CENTER_Y);
      cnt_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      dx_q    <= dx_nx;
      dy_q    <= dy_nx;
      x_q     <= x_nx;
      y_q     <= y_nx;
      cnt_q   <= cnt_nx;
      hit_q   <= hit_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    dx_nx    = dx_q;
    dy_nx    = dy_q;
    x_nx     = x_q;
    y_nx     = y_q;
    cnt_nx   = cnt_q;
    hit_nx   = 1'b0;

    if (frame_tick) begin
      unique case (state_q)
        SERVE: begin
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            state_nx = MOVING;
            dx_nx    = serve_right ? POS : NEG;
            dy_nx    = POS;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_q + CNT_W'(1);
          end
        end

        MOVING: begin
          if (ny < Y_MIN_S) begin
            y_nx  = POS_W'(Y_MIN);
            dy_nx = POS;
          end else if (ny > Y_MAX_S) begin
            y_nx  = POS_W'(Y_MAX);
            dy_nx = NEG;
          end else begin
            y_nx = ny[POS_W-1:0];
          end

          // Paddle rebounds win over the goal clamp
          if (hit_l) begin
            x_nx   = POS_W'(LEFT_REBOUND_X);
            dx_nx  = POS;
            hit_nx = 1'b1;
          end else if (hit_r) begin
            x_nx   = POS_W'(RIGHT_REBOUND_X);
            dx_nx  = NEG;
            hit_nx = 1'b1;
          end else if (nx <= X_MIN_S) begin
            x_nx     = POS_W'(X_MIN);
            state_nx = OUT;
          end else if (nx >= X_MAX_S) begin
            x_nx     = POS_W'(X_MAX);
            state_nx = OUT;
          end else begin
            x_nx = nx[POS_W-1:0];
          end
        end

        OUT: begin
        end

        default: begin
          state_nx = SERVE;
        end
      endcase
    end
  end

  assign ball_x_pos = x_q;
  assign ball_y_pos = y_q;
  assign paddle_hit = hit_q;
  assign in_play    = (state_q == MOVING);

endmodule

// File: tb/tb_ball_controller.sv
// Directed scoreboard bench for ball_controller. Expected trajectories are
// hand-derived closed forms (x = 320 -/+ 2k, y = 240 + k, bounce offsets).
module tb_ball_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       serve_right = 1'b0;
  logic [9:0] left_paddle_y = '0;
  logic [9:0] right_paddle_y = '0;
  logic [9:0] ball_x_pos;
  logic [9:0] ball_y_pos;
  logic       paddle_hit;
  logic       in_play;

  ball_controller dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_tick     (frame_tick),
    .serve_right    (serve_right),
    .left_paddle_y  (left_paddle_y),
    .right_paddle_y (right_paddle_y),
    .ball_x_pos     (ball_x_pos),
    .ball_y_pos     (ball_y_pos),
    .paddle_hit     (paddle_hit),
    .in_play        (in_play)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ph;
    int         idx;
    logic [9:0] x;
    logic [9:0] y;
    logic       ip;
    logic       hit;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic async_tgl = 1'b0;
  logic fin_tgl   = 1'b0;
  logic tick_seen, tick_d;

  // Marks the negedge following a frame_tick posedge (output sample point)
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_seen <= 1'b0;
      tick_d    <= 1'b0;
    end else begin
      tick_seen <= frame_tick;
      tick_d    <= tick_seen;
    end
  end

  task automatic push_exp(input int ph, input int idx, input int ex, input int ey,
                          input logic eip, input logic ehit);
    exp_t e;
    e.ph = ph; e.idx = idx; e.x = 10'(ex); e.y = 10'(ey); e.ip = eip; e.hit = ehit;
    sb.push_back(e);
  endtask

  task automatic tick(input int ph, input int idx, input int ex, input int ey,
                      input logic eip, input logic ehit);
    @(negedge clk);
    frame_tick = 1'b1;
    push_exp(ph, idx, ex, ey, eip, ehit);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic async_check(input int ph, input int ex, input int ey);
    push_exp(ph, 0, ex, ey, 1'b0, 1'b0);
    async_tgl = ~async_tgl;
  endtask

  task automatic serve_hold(input int ph);
    for (int i = 1; i <= 59; i++) tick(ph, i, 320, 240, 1'b0, 1'b0);
    tick(ph, 60, 320, 240, 1'b1, 1'b0);
  endtask

  // Monitor: sole owner of the scoreboard counters
  initial begin : monitor
    exp_t e;
    logic async_seen;
    logic fin_seen;
    async_seen = 1'b0;
    fin_seen   = 1'b0;
    forever begin
      @(negedge clk or async_tgl or fin_tgl);
      if (fin_tgl != fin_seen) begin
        fin_seen = fin_tgl;
        n_tests++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end else if (async_tgl != async_seen) begin
        async_seen = async_tgl;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL async_sb_empty: no expectation queued");
        end else begin
          e = sb.pop_front();
          if ({ball_x_pos, ball_y_pos, in_play, paddle_hit} !== {e.x, e.y, e.ip, e.hit}) begin
            n_fail++;
            $display("FAIL async_reset ph=%0d: got x=%0d y=%0d ip=%b hit=%b, required x=%0d y=%0d ip=%b hit=%b",
                     e.ph, ball_x_pos, ball_y_pos, in_play, paddle_hit, e.x, e.y, e.ip, e.hit);
          end
        end
      end else if (tick_seen) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL tick_sb_empty: output presented with no expectation");
        end else begin
          e = sb.pop_front();
          if ({ball_x_pos, ball_y_pos, in_play, paddle_hit} !== {e.x, e.y, e.ip, e.hit}) begin
            n_fail++;
            $display("FAIL tick ph=%0d idx=%0d: got x=%0d y=%0d ip=%b hit=%b, required x=%0d y=%0d ip=%b hit=%b",
                     e.ph, e.idx, ball_x_pos, ball_y_pos, in_play, paddle_hit, e.x, e.y, e.ip, e.hit);
          end
        end
      end else if (tick_d) begin
        n_tests++;
        if (paddle_hit !== 1'b0) begin
          n_fail++;
          $display("FAIL hit_pulse_width: paddle_hit=%b one cycle after tick, required 0", paddle_hit);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int ey;
    #2 reset_n = 1'b0;
    #1 async_check(0, 320, 240);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Leftward serve, left paddle positioned where the ball arrives (y=383)
    left_paddle_y  = 10'd360;
    right_paddle_y = 10'd250;
    serve_right    = 1'b0;
    serve_hold(1);
    for (int k = 1; k <= 143; k++) tick(2, k, 320 - 2*k, 240 + k, 1'b1, 1'b0);
    tick(3, 144, 33, 384, 1'b1, 1'b1);

    // Back to the right; floor reached at j=90, held at j=91, then descending
    for (int j = 1; j <= 286; j++) begin
      if (j <= 90)      ey = 384 + j;
      else if (j == 91) ey = 474;
      else              ey = 565 - j;
      tick(4, j, 33 + 2*j, ey, 1'b1, 1'b0);
    end
    tick(5, 287, 607, 278, 1'b1, 1'b1);

    // Leftward and up to the ceiling: y=5 at m=273, held at m=274, then rising
    for (int m = 1; m <= 276; m++) begin
      ey = (m <= 273) ? (278 - m) : (5 + (m - 274));
      tick(6, m, 607 - 2*m, ey, 1'b1, 1'b0);
    end

    // Mid-flight asynchronous reset; ticks during reset are ignored
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 async_check(7, 320, 240);
    repeat (4) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
    #1 async_check(7, 320, 240);
    @(negedge clk);
    reset_n = 1'b1;

    // Leftward serve with the left paddle out of reach: goal at x=5
    left_paddle_y = 10'd0;
    serve_right   = 1'b0;
    serve_hold(8);
    for (int k = 1; k <= 157; k++) tick(9, k, 320 - 2*k, 240 + k, 1'b1, 1'b0);
    tick(9, 158, 5, 398, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) tick(10, i, 5, 398, 1'b0, 1'b0);

    // One-cycle goal reset pulse
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1 async_check(11, 320, 240);

    // Rightward serve with the right paddle out of reach: goal at x=634
    right_paddle_y = 10'd300;
    serve_right    = 1'b1;
    serve_hold(12);
    for (int k = 1; k <= 156; k++) tick(13, k, 320 + 2*k, 240 + k, 1'b1, 1'b0);
    tick(13, 157, 634, 397, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) tick(14, i, 634, 397, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    #1 fin_tgl = ~fin_tgl;
  end

endmodule
